// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader state encoding and stream widths
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_RUN,
        ST_ERR
    } load_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - big-endian byte-to-word assembly
module word_assembler
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_done
);

    logic [WORD_W-1:0] shreg;
    logic [1:0]        byte_cnt;

    // The word including the byte being accepted now, so the caller can register it on the same edge
    assign word_next = {shreg[WORD_W-BYTE_W-1:0], byte_in};
    assign word_done = shift && (byte_cnt == 2'd3);

    // Shift bytes in most-significant first; the byte counter wraps 3->0 as each word completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            shreg    <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that fills instruction memory then releases the core
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    // Word count N may equal the full capacity, hence one extra bit in the comparison
    localparam logic [LEN_W:0] CAPACITY = (LEN_W+1)'(1) << ADDR_W;

    load_state_t       state;
    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W:0]   word_cnt;

    logic              restart;
    logic              accept;
    logic [LEN_W-1:0]  len_full;
    logic              last_word;
    logic              asm_clear;
    logic              asm_shift;
    logic [WORD_W-1:0] word_next;
    logic              word_done;

    // A start in LEN_HI is a no-op; everywhere else it aborts the load
    assign restart   = start && (state != ST_LEN_HI);
    assign in_ready  = ((state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA)) && !start;
    assign accept    = in_valid && in_ready;
    assign len_full  = {len_hi, in_data};
    assign last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == len;
    assign asm_clear = restart || ((state == ST_LEN_LO) && accept);
    assign asm_shift = (state == ST_DATA) && accept;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift     (asm_shift),
        .byte_in   (in_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    // Load FSM with word counter and registered memory/core-control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LEN_HI;
            len_hi     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (restart) begin
                state     <= ST_LEN_HI;
                word_cnt  <= '0;
                cpu_reset <= 1'b1;
                err       <= 1'b0;
            end else begin
                case (state)
                    ST_LEN_HI: begin
                        if (accept) begin
                            len_hi <= in_data;
                            state  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (accept) begin
                            len      <= len_full;
                            word_cnt <= '0;
                            if (len_full == '0) begin
                                state <= ST_RUN;
                            end else if ({1'b0, len_full} > CAPACITY) begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (word_done) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= word_next;
                            word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                            if (last_word) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        // Release one cycle after entering RUN so the last write lands first
                        if (cpu_reset) begin
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    default: begin
                        err       <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy_a, we_a, cr_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic        rdy_b, we_b, cr_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          gpr [32];

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        cr;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (rdy_a),
        .imem_we    (we_a),
        .imem_addr  (addr_a),
        .imem_wdata (wdata_a),
        .cpu_reset  (cr_a),
        .done       (done_a),
        .err        (err_a)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (rdy_b),
        .imem_we    (we_b),
        .imem_addr  (addr_b),
        .imem_wdata (wdata_b),
        .cpu_reset  (cr_b),
        .done       (done_b),
        .err        (err_b)
    );

    always @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
            wr_cnt      <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic rdy,
                                input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic cr, input logic dn, input logic er);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
        r.wdata = wdata; r.cr = cr; r.done = dn; r.err = er;
        return r;
    endfunction

    logic [7:0]  gap_bytes [10];
    logic [31:0] exp_words [2];
    int          wc;
    logic [31:0] ins;

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // nominal load: 00 02 | 20 08 00 05 | 20 09 00 07
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 1, 0, 8'h00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h20, 1, 0, 8'h00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h08, 1, 0, 8'h00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 1, 1, 8'h00, 32'h20080005, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h20, 1, 0, 8'h00, 32'h20080005, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h09, 1, 0, 8'h00, 32'h20080005, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h00, 32'h20080005, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h07, 1, 1, 8'h01, 32'h20090007, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 8'h01, 32'h20090007, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 32'h20090007, 0, 0, 0));
        // zero length: start, 00 00, release two edges after LEN_LO
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h01, 32'h20090007, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 32'h20090007, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 32'h20090007, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 32'h20090007, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 32'h20090007, 0, 0, 0));

        gap_bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        exp_words = '{32'h20080005, 32'h20090007};

        // reset values, held and after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cr_a, 1);
        chk("rst_we", we_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ready", rdy_a, 1);
        reset = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].s; in_valid = tbl[i].v; in_data = tbl[i].d;
            #1;
            chk($sformatf("v%0d_ready", i), rdy_a, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), we_a, tbl[i].we);
            chk($sformatf("v%0d_addr", i), addr_a, tbl[i].addr);
            chk($sformatf("v%0d_wdata", i), wdata_a, tbl[i].wdata);
            chk($sformatf("v%0d_cpu_reset", i), cr_a, tbl[i].cr);
            chk($sformatf("v%0d_done", i), done_a, tbl[i].done);
            chk($sformatf("v%0d_err", i), err_a, tbl[i].err);
        end

        // gapped stream: in_valid low every other cycle
        cyc(1, 0, 8'h00);
        chk("gap_start_cpu_reset", cr_a, 1);
        wc = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 8'hFF);
            chk($sformatf("gap%0d_idle_we", i), we_a, 0);
            cyc(0, 1, gap_bytes[i]);
            if (i >= 2 && ((i - 2) % 4) == 3) begin
                chk($sformatf("gap%0d_we", i), we_a, 1);
                chk($sformatf("gap%0d_addr", i), addr_a, (i - 2) / 4);
                chk($sformatf("gap%0d_wdata", i), wdata_a, exp_words[(i - 2) / 4]);
            end else begin
                chk($sformatf("gap%0d_we", i), we_a, 0);
            end
        end
        cyc(0, 0, 8'h00);
        chk("gap_done", done_a, 1);
        chk("gap_cpu_reset", cr_a, 0);
        chk("gap_write_count", wr_cnt - wc, 2);

        // execute the loaded addi instructions on a tiny register model
        for (int r = 0; r < 32; r++) gpr[r] = 0;
        for (int w = 0; w < 2; w++) begin
            ins = mem[w];
            if (ins[31:26] == 6'h08)
                gpr[ins[20:16]] = gpr[ins[25:21]] + int'($signed(ins[15:0]));
        end
        chk("mon_t0", gpr[8], 5);
        chk("mon_t1", gpr[9], 7);

        // overflow on the 4-word instance, then exact capacity is accepted
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h05);
        chk("ovf_err", err_b, 1);
        chk("ovf_cpu_reset", cr_b, 1);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("ovf_ready", rdy_b, 0);
        @(posedge clk);
        #1;
        cyc(0, 0, 8'h00);
        chk("ovf_err_held", err_b, 1);
        chk("ovf_cpu_reset_held", cr_b, 1);
        cyc(1, 0, 8'h00);
        chk("ovf_start_err", err_b, 0);
        chk("ovf_start_cpu_reset", cr_b, 1);
        start = 1'b0; in_valid = 1'b0;
        #1;
        chk("ovf_start_ready", rdy_b, 1);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h04);
        chk("cap_err", err_b, 0);
        in_valid = 1'b0;
        #1;
        chk("cap_ready", rdy_b, 1);

        // restart after two bytes of a word, with a byte offered alongside start
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'hDE);
        cyc(0, 1, 8'hAD);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hBE;
        #1;
        chk("rs_ready_with_start", rdy_a, 0);
        @(posedge clk);
        #1;
        chk("rs_we", we_a, 0);
        chk("rs_cpu_reset", cr_a, 1);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h11);
        cyc(0, 1, 8'h22);
        cyc(0, 1, 8'h33);
        cyc(0, 1, 8'h44);
        chk("rs_reload_we", we_a, 1);
        chk("rs_reload_addr", addr_a, 0);
        chk("rs_reload_wdata", wdata_a, 32'h11223344);
        cyc(0, 0, 8'h00);
        chk("rs_reload_done", done_a, 1);

        // asynchronous reset while a write strobe is up
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h02);
        cyc(0, 1, 8'hCA);
        cyc(0, 1, 8'hFE);
        cyc(0, 1, 8'hBA);
        cyc(0, 1, 8'hBE);
        chk("ar_pre_we", we_a, 1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_cpu_reset", cr_a, 1);
        chk("ar_we", we_a, 0);
        chk("ar_addr", addr_a, 0);
        chk("ar_wdata", wdata_a, 0);
        chk("ar_ready", rdy_a, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h0A);
        cyc(0, 1, 8'h0B);
        cyc(0, 1, 8'h0C);
        cyc(0, 1, 8'h0D);
        chk("ar_reload_we", we_a, 1);
        chk("ar_reload_addr", addr_a, 0);
        chk("ar_reload_wdata", wdata_a, 32'h0A0B0C0D);
        cyc(0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
